// File: rtl/md_pkg.sv
// md_pkg: shared state encoding and constants for the iterative multiply/divide unit.
package md_pkg;
    localparam int MD_W = 32;
    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_DONE} md_state_e;
    localparam logic [63:0] MD_DIVZ_Q = '1;
endpackage

// File: rtl/md_sign_adjust.sv
// md_sign_adjust: conditional two's-complement negate (abs on entry, sign fix on exit).
module md_sign_adjust import md_pkg::*; #(
    parameter int W = MD_W
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] out
);
    assign out = neg ? -val : val;
endmodule

// File: rtl/md_iter_unit.sv
// md_iter_unit: iterative MIPS multiply/divide; shift-add multiply, restoring divide.
// MD_FAST_MUL_EN: single-cycle W x W multiply instead of the iterative shift-add.
module md_iter_unit import md_pkg::*; #(
    parameter int W     = MD_W,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           mult_en,
    input  logic           div_en,
    input  logic           is_signed,
    input  logic [W-1:0]   src1,
    input  logic [W-1:0]   src2,
    input  logic           flush,
    output logic           busy,
    output logic           complete,
    output logic [2*W-1:0] result,
    output logic           div_by_zero
);
`ifdef MD_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     a, b, a_abs, b_abs, rem, rem_nxt, rem_fix;
    logic [2*W-1:0]   p, p_mul, res_in, res_fix;
    logic [W-1:0]     dq_nxt;
    logic [W:0]       shl;
    logic [W+1:0]     trial;
    logic             sdiff, sdvd, dz, last, start, res_neg;
    md_sign_adjust #(.W(W)) u_abs1 (.val(src1), .neg(is_signed & src1[W-1]), .out(a_abs));
    md_sign_adjust #(.W(W)) u_abs2 (.val(src2), .neg(is_signed & src2[W-1]), .out(b_abs));
    md_sign_adjust #(.W(2*W)) u_fix (.val(res_in), .neg(res_neg), .out(res_fix));
    md_sign_adjust #(.W(W)) u_rem (.val(rem_nxt), .neg(sdvd), .out(rem_fix));
`ifdef MD_FAST_MUL_EN
    assign p_mul = {{W{1'b0}}, a} * {{W{1'b0}}, b};
`else
    logic [W:0] sum;
    assign sum   = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a} : '0);
    assign p_mul = {sum, p[W-1:1]};
`endif
    always_comb begin
        start       = (mult_en | div_en) & ~flush;
        last        = cnt == CNT_W'(W-1);
        busy        = state == MD_MUL || state == MD_DIV || (state == MD_IDLE && start);
        complete    = state == MD_DONE;
        div_by_zero = complete & dz;
        shl         = {rem, p[W-1]};
        trial       = {1'b0, shl} - {2'b0, b};
        rem_nxt     = trial[W+1] ? shl[W-1:0] : trial[W-1:0];
        dq_nxt      = {p[W-2:0], ~trial[W+1]};
        res_in      = state == MD_MUL ? p_mul : {{W{1'b0}}, dq_nxt};
        // a zero divisor keeps the all-ones quotient; remainder returns to src1 naturally
        res_neg     = sdiff & (state == MD_MUL || !dz);
        state_nxt   = flush ? MD_IDLE :
                      state == MD_IDLE ? (start ? (div_en ? MD_DIV : MD_MUL) : MD_IDLE) :
                      state == MD_DONE ? MD_IDLE :
                      (last || (FAST && state == MD_MUL)) ? MD_DONE : state;
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= MD_IDLE;
        else state <= state_nxt;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            a      <= '0;
            b      <= '0;
            p      <= '0;
            rem    <= '0;
            sdiff  <= 1'b0;
            sdvd   <= 1'b0;
            dz     <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                MD_IDLE: if (start) begin
                    a     <= a_abs;
                    b     <= b_abs;
                    p     <= {{W{1'b0}}, div_en ? a_abs : b_abs};
                    rem   <= '0;
                    cnt   <= '0;
                    sdiff <= is_signed & (src1[W-1] ^ src2[W-1]);
                    sdvd  <= is_signed & src1[W-1];
                    dz    <= div_en && src2 == '0;
                end
                MD_MUL: begin
                    p   <= p_mul;
                    cnt <= cnt + 1'b1;
                    if ((last || FAST) && !flush) result <= res_fix;
                end
                MD_DIV: begin
                    p   <= {p[2*W-1:W], dq_nxt};
                    rem <= rem_nxt;
                    cnt <= cnt + 1'b1;
                    if (last && !flush) result <= {rem_fix, res_fix[W-1:0]};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_md_iter_unit.sv
// tb_md_iter_unit: scoreboard bench for md_iter_unit (directed cases plus modelled random ops).
module tb_md_iter_unit;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mult_en = 1'b0, div_en = 1'b0, is_signed = 1'b0, flush = 1'b0;
    logic [31:0] src1 = '0, src2 = '0;
    logic        busy, complete, div_by_zero;
    logic [63:0] result;
    int          errors = 0, checks = 0, cyc = 0;
`ifdef MD_FAST_MUL_EN
    localparam int MLAT = 2;
`else
    localparam int MLAT = 33;
`endif
    localparam int DLAT = 33;
    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          at;
    } exp_t;
    exp_t sb[$];

    md_iter_unit dut (
        .clk(clk), .resetn(resetn), .mult_en(mult_en), .div_en(div_en),
        .is_signed(is_signed), .src1(src1), .src2(src2), .flush(flush),
        .busy(busy), .complete(complete), .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] model(input logic d, input logic s, input logic [31:0] x, input logic [31:0] y);
        longint xs, ys, q, r;
        xs = s ? longint'($signed(x)) : longint'({32'b0, x});
        ys = s ? longint'($signed(y)) : longint'({32'b0, y});
        if (!d) return {1'b0, 64'(xs * ys)};
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        q = xs / ys;
        r = xs % ys;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    always @(negedge clk) if (complete) begin
        if (sb.size() == 0) chk("spurious_complete", 1, 0);
        else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("div_by_zero", div_by_zero, e.dz);
            chk("complete_cycle", cyc, e.at);
        end
    end

    // called at a negedge; returns at the negedge after the DONE cycle
    task automatic run_op(input logic m, input logic d, input logic s, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] er, input logic ez, input int lat);
        int n;
        mult_en = m; div_en = d; is_signed = s; src1 = x; src2 = y;
        #1 chk("busy_start", busy, 1);
        sb.push_back('{er, ez, cyc + lat});
        @(negedge clk);
        mult_en = 0; div_en = 0; src1 = $urandom; src2 = $urandom;
        n = 1;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("busy_len", n, lat);
        @(negedge clk);
    endtask

    task automatic run_model(input logic d, input logic s, input logic [31:0] x, input logic [31:0] y);
        logic [64:0] m;
        m = model(d, s, x, y);
        run_op(!d, d, s, x, y, m[63:0], m[64], d ? DLAT : MLAT);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout got=%0d exp=0", cyc);
        $fatal(1);
    end

    initial begin
        logic [63:0] prev;
        repeat (3) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_complete", complete, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dbz", div_by_zero, 0);
        resetn = 1;
        @(negedge clk);
        run_op(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, MLAT);
        run_op(1, 0, 1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0, MLAT);
        run_op(0, 1, 1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, DLAT);
        run_op(0, 1, 0, 32'hFFFF_FFF9, 32'd2, 64'h0000_0001_7FFF_FFFC, 0, DLAT);
        run_op(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, DLAT);
        run_op(0, 1, 0, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1, DLAT);
        run_op(0, 1, 1, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 1, DLAT);
        run_op(1, 1, 0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0, DLAT);
        for (int i = 0; i < 10; i++)
            run_model(i[0], i[1], $urandom, (i == 8) ? 32'd0 : $urandom);
        run_model(1, 1, 32'h8000_0000, 32'd1);
        prev = result;
        mult_en = 1; flush = 1;
        #1 chk("flush_start_busy", busy, 0);
        @(negedge clk);
        mult_en = 0; flush = 0;
        chk("flush_start_idle", busy, 0);
        div_en = 1; is_signed = 1; src1 = 32'd1000; src2 = 32'd3;
        @(negedge clk);
        div_en = 0;
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        #1 chk("flush_busy", busy, 0);
        chk("flush_result", result, prev);
        run_op(1, 0, 0, 32'd2, 32'd3, 64'd6, 0, MLAT);
        mult_en = 1; src1 = 32'd9; src2 = 32'd9;
        @(negedge clk);
        mult_en = 0;
        repeat (5) @(negedge clk);
        resetn = 0;
        #1 chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        chk("midrst_complete", complete, 0);
        @(negedge clk);
        resetn = 1;
        repeat (40) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
